imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Pipelined, parametrised successor to the combinational immediate generator.
//  - Decodes all RV base immediate formats: I, S, B, U, J, plus R-type (imm=0).
//  - Sits between fetch and register-read. Carries a caller tag (PC/ROB id) alongside each instruction.
//  - Two register stages with valid/ready backpressure, a pipeline flush and a saturating illegal-opcode counter.
// PARAMETERS
//  XLEN          64  immediate output width; legal values 32 or 64
//  BRANCH_SCALED 0   0: B/J offsets in halfword units (legacy, imm>>1); 1: byte offsets
//  TAG_W         8   width of pass-through tag
//  CNT_W         16  width of illegal-instruction counter
// PORTS
//  clk            in   1      clock, rising edge
//  reset          in   1      synchronous, active-high reset
//  flush          in   1      drop all in-flight entries
//  in_valid       in   1      in_instr/in_tag valid
//  in_ready       out  1      stage 1 can accept this cycle
//  in_instr       in   32     raw instruction word
//  in_tag         in   TAG_W  opaque tag, returned unchanged
//  out_valid      out  1      result valid
//  out_ready      in   1      consumer accepts result
//  out_imm        out  XLEN   sign-extended immediate
//  out_fmt        out  3      0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
//  out_illegal    out  1      opcode not recognised
//  out_tag        out  TAG_W  tag of the result
//  illegal_count  out  CNT_W  count of illegal results accepted at output, saturating
// BEHAVIOUR
//  Reset: s1_valid=s2_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, illegal_count=0.
//  Pipeline: S1 registers instr+tag; S2 registers decoded imm/fmt/illegal+tag.
//  - s2_adv = !s2_valid | out_ready;  s1_adv = !s1_valid | s2_adv
//  - in_ready = s1_adv (combinational from out_ready).
//  - Transfer occurs on valid&ready. Latency is exactly 2 cycles with no stall.
//  - Throughput is 1/cycle. A stalled stage holds all fields stable.
//  Opcode decode (instr[6:0]):
//  - I: 0000011 0010011 0011011 1100111 1110011
//  - S: 0100011
//  - B: 1100011
//  - U: 0110111 0010111
//  - J: 1101111
//  - R: 0110011 0111011 -> imm 0
//  - Anything else: fmt=7, illegal=1, imm=0.
//  Immediate assembly (then sign-extend bit 31 of instr to XLEN):
//  - I: instr[31:20]
//  - S: {instr[31:25],instr[11:7]}
//  - B: {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}
//  - J: {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}
//  - B/J with BRANCH_SCALED=0: arithmetic shift right by 1.
//  - U: {instr[31:12],12'b0}. For XLEN=64 bits 63:32 copy instr[31].
//  Flush: both stages invalid at next edge. Input offered in a flush cycle is dropped.
//  - in_ready is still computed normally.
//  - illegal_count is not changed by flush.
//  Priority: reset > flush > normal advance.
//  illegal_count: +1 on out_valid&out_ready&out_illegal. Holds at 2^CNT_W-1.
//  Reset mid-stream: every in-flight entry is discarded with no output.
// TESTING
//  - 0x00F23403 (ld) -> 2 cycles later out_imm=15, fmt=1, tag echoed.
//  - 0x828237A3 (sd) -> out_imm=-2001 fmt=2.
//  - 0x00820833 (add) -> out_imm=0 fmt=0.
//  - 0x12345037 (lui) -> out_imm=0x12345000 fmt=4.
//  - 0xA4820F63 (beq) -> BRANCH_SCALED=0: -1745; BRANCH_SCALED=1: -3490. fmt=3.
//  - Backpressure: stream 4 instrs, out_ready=0 for 5 cycles.
//    -> in_ready=0 after 2 accepts. Then all 4 results arrive in order with no loss or duplication.
//  - Flush with 2 in flight -> no out_valid next cycle.
//  - Illegal stream: 0x0000007F x3 accepted -> illegal_count=3.
//  - CNT_W=2 saturates at 3.

Source files
------------

// File: rtl/imm_gen_pipe_if.sv
// Stream interface for the pipelined immediate generator: an instruction/tag
// input stream and a decoded-immediate output stream, each with valid/ready.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Two-stage pipelined RISC-V immediate generator with valid/ready flow
// control, flush, a pass-through tag and a saturating illegal-opcode counter.
module imm_gen_pipe #(
  parameter int XLEN          = 64,
  parameter int BRANCH_SCALED = 0,
  parameter int TAG_W         = 8,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  imm_gen_pipe_if.slave    bus,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic signed [XLEN-1:0] imm;
    logic [2:0]             fmt;
    logic                   illegal;
  } dec_t;

  // Opcode decode and immediate assembly; the 32-bit result is sign-extended to XLEN.
  function automatic dec_t decode(input logic [31:0] instr);
    logic signed [31:0] imm32;
    dec_t               d;
    imm32     = '0;
    d.fmt     = FMT_R;
    d.illegal = 1'b0;
    case (instr[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: begin
        d.fmt = FMT_I;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      7'b0100011: begin
        d.fmt = FMT_S;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      7'b1100011: begin
        d.fmt = FMT_B;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        if (BRANCH_SCALED == 0) imm32 = imm32 >>> 1;
      end
      7'b0110111, 7'b0010111: begin
        d.fmt = FMT_U;
        imm32 = {instr[31:12], 12'b0};
      end
      7'b1101111: begin
        d.fmt = FMT_J;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        if (BRANCH_SCALED == 0) imm32 = imm32 >>> 1;
      end
      7'b0110011, 7'b0111011: begin
        d.fmt = FMT_R;
      end
      default: begin
        d.fmt     = FMT_ILL;
        d.illegal = 1'b1;
      end
    endcase
    d.imm = XLEN'(imm32);
    return d;
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic                    vld_p1;
  logic                    vld_p2;
  logic [31:0]             instr_p1;
  logic [TAG_W-1:0]        tag_p1;
  logic signed [XLEN-1:0]  imm_p2;
  logic [2:0]              fmt_p2;
  logic                    ill_p2;
  logic [TAG_W-1:0]        tag_p2;
  logic                    s1_adv;
  logic                    s2_adv;
  dec_t                    dec_p1;
  logic [CNT_W-1:0]        cnt_q;

  assign s2_adv = !vld_p2 || bus.out_ready;
  assign s1_adv = !vld_p1 || s2_adv;

  assign bus.in_ready    = s1_adv;
  assign bus.out_valid   = vld_p2;
  assign bus.out_imm     = imm_p2;
  assign bus.out_fmt     = fmt_p2;
  assign bus.out_illegal = ill_p2;
  assign bus.out_tag     = tag_p2;
  assign illegal_count   = cnt_q;

  // Stage valids: reset beats flush, flush beats normal advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (s1_adv) vld_p1 <= bus.in_valid;
      if (s2_adv) vld_p2 <= vld_p1;
    end
  end

  // ---- stage 1: capture raw instruction and tag ----
  // Stage-1 payload loads only on an accepted offer, otherwise holds.
  always_ff @(posedge clk) begin
    if (s1_adv && bus.in_valid) begin
      instr_p1 <= bus.in_instr;
      tag_p1   <= bus.in_tag;
    end
  end

  // Decode from the stage-1 register so the output stage sees a full cycle of logic.
  always_comb begin
    dec_p1 = decode(instr_p1);
  end

  // ---- stage 2: decoded immediate, format and tag ----
  // Output payload is cleared on reset so the visible result fields are defined.
  always_ff @(posedge clk) begin
    if (reset) begin
      imm_p2 <= '0;
      fmt_p2 <= FMT_R;
      ill_p2 <= 1'b0;
      tag_p2 <= '0;
    end else if (s2_adv && vld_p1) begin
      imm_p2 <= dec_p1.imm;
      fmt_p2 <= dec_p1.fmt;
      ill_p2 <= dec_p1.illegal;
      tag_p2 <= tag_p1;
    end
  end

  // Count illegal results as they are handed to the consumer; flush does not touch it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (vld_p2 && bus.out_ready && ill_p2) begin
      cnt_q <= sat_inc(cnt_q);
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: two instances (XLEN=64 halfword branches with a
// 2-bit counter, XLEN=32 byte branches with a 16-bit counter) share one
// stimulus stream and are scored against an arithmetic reference model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [7:0]  in_tag;
  logic [1:0]  cnt0;
  logic [15:0] cnt1;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) bus0 ();
  imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_instr  = in_instr;
  assign bus0.in_tag    = in_tag;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_instr  = in_instr;
  assign bus1.in_tag    = in_tag;
  assign bus1.out_ready = out_ready;

  imm_gen_pipe #(.XLEN(64), .BRANCH_SCALED(0), .TAG_W(8), .CNT_W(2)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus0), .illegal_count(cnt0)
  );
  imm_gen_pipe #(.XLEN(32), .BRANCH_SCALED(1), .TAG_W(8), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus1), .illegal_count(cnt1)
  );

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  tag;
  } ent_t;

  ent_t   q[$];
  ent_t   e;
  int     nchk = 0;
  int     nerr = 0;
  int     n_out = 0;
  longint mcnt = 0;

  localparam logic [6:0] OPS [12] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23,
                                      7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Reference model: format class from the opcode tables.
  function automatic int ref_fmt(input logic [31:0] i);
    case (i[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: return 1;
      7'h23:                             return 2;
      7'h63:                             return 3;
      7'h37, 7'h17:                      return 4;
      7'h6F:                             return 5;
      7'h33, 7'h3B:                      return 0;
      default:                           return 7;
    endcase
  endfunction

  function automatic longint sx(input longint v, input int bits);
    longint half;
    half = longint'(1) << (bits - 1);
    if (v >= half) return v - (half * 2);
    return v;
  endfunction

  // Reference model: immediate value as a plain integer built from field weights.
  function automatic longint ref_imm(input logic [31:0] i, input bit scaled);
    longint u;
    longint v;
    u = longint'({32'd0, i});
    v = 0;
    case (ref_fmt(i))
      1: v = sx(u >> 20, 12);
      2: v = sx(((u >> 25) & 127) * 32 + ((u >> 7) & 31), 12);
      3: begin
        v = sx(((u >> 31) & 1) * 4096 + ((u >> 7) & 1) * 2048 +
               ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2, 13);
        if (!scaled) v = v / 2;
      end
      4: v = sx(u & 64'hFFFF_F000, 32);
      5: begin
        v = sx(((u >> 31) & 1) * 1048576 + ((u >> 12) & 255) * 4096 +
               ((u >> 20) & 1) * 2048 + ((u >> 21) & 1023) * 2, 21);
        if (!scaled) v = v / 2;
      end
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 13);
    if (k < 12) r[6:0] = OPS[k];
    return r;
  endfunction

  // Scoreboard: compare every accepted output, then record this cycle's accepted input.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      mcnt = 0;
    end else begin
      check("cnt0", 64'(cnt0), (mcnt > 3) ? 3 : mcnt);
      check("cnt1", 64'(cnt1), (mcnt > 65535) ? 65535 : mcnt);
      if (bus0.out_valid === 1'b1 && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", 64'(bus0.out_valid), 0);
        end else begin
          e = q.pop_front();
          n_out++;
          check("imm64", bus0.out_imm, ref_imm(e.instr, 1'b0));
          check("imm32", {{32{bus1.out_imm[31]}}, bus1.out_imm}, ref_imm(e.instr, 1'b1));
          check("fmt", 64'(bus0.out_fmt), 64'(ref_fmt(e.instr)));
          check("fmt32", 64'(bus1.out_fmt), 64'(ref_fmt(e.instr)));
          check("illegal", 64'(bus0.out_illegal), 64'(ref_fmt(e.instr) == 7));
          check("tag", 64'(bus0.out_tag), 64'(e.tag));
          check("tag32", 64'(bus1.out_tag), 64'(e.tag));
          check("vld32", 64'(bus1.out_valid), 1);
          if (ref_fmt(e.instr) == 7) mcnt++;
        end
      end
      if (flush) q.delete();
      else if (in_valid && bus0.in_ready) q.push_back('{instr: in_instr, tag: in_tag});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [7:0] tg);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_instr = ins;
    in_tag   = tg;
    acc      = 1'b0;
    n        = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus0.in_ready;
      n++;
      tick();
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 64'(acc), 1);
  endtask

  task automatic directed(input string nm, input logic [31:0] ins, input logic [7:0] tg,
                          input longint e64, input longint e32, input int f);
    out_ready = 1'b1;
    send(ins, tg);
    @(negedge clk);
    check({nm, "_lat1"}, 64'(bus0.out_valid), 0);
    @(negedge clk);
    check({nm, "_vld"}, 64'(bus0.out_valid), 1);
    check({nm, "_imm64"}, bus0.out_imm, e64);
    check({nm, "_imm32"}, {{32{bus1.out_imm[31]}}, bus1.out_imm}, e32);
    check({nm, "_fmt"}, 64'(bus0.out_fmt), 64'(f));
    check({nm, "_tag"}, 64'(bus0.out_tag), 64'(tg));
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected the bench to finish");
    $fatal(1);
  end

  initial begin
    int nb;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_tag = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_vld", 64'(bus0.out_valid), 0);
    check("rst_imm", bus0.out_imm, 0);
    check("rst_fmt", 64'(bus0.out_fmt), 0);
    check("rst_ill", 64'(bus0.out_illegal), 0);
    check("rst_tag", 64'(bus0.out_tag), 0);
    check("rst_cnt", 64'(cnt0), 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rdy_empty", 64'(bus0.in_ready), 1);
    tick();

    directed("ld",  32'h00F23403, 8'h11, 15, 15, 1);
    directed("sd",  32'h828237A3, 8'h22, -2001, -2001, 2);
    directed("add", 32'h00820833, 8'h33, 0, 0, 0);
    directed("lui", 32'h12345037, 8'h44, 64'h12345000, 64'h12345000, 4);
    directed("beq", 32'hA4820F63, 8'h55, -1745, -3490, 3);

    // Backpressure: two accepts then a stall, then everything drains in order.
    nb = n_out;
    out_ready = 1'b0;
    send(32'h00F23403, 8'h60);
    send(32'hA4820F63, 8'h61);
    in_valid = 1'b1; in_instr = 32'h12345037; in_tag = 8'h62;
    repeat (3) begin
      @(negedge clk);
      check("bp_rdy", 64'(bus0.in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    send(32'h12345037, 8'h62);
    send(32'h828237A3, 8'h63);
    repeat (6) tick();
    check("bp_count", 64'(n_out - nb), 4);

    // Flush with two in flight; the offer made during the flush is dropped.
    nb = n_out;
    out_ready = 1'b0;
    send(32'h00F23403, 8'h70);
    send(32'h00820833, 8'h71);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h12345037; in_tag = 8'h72;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_vld", 64'(bus0.out_valid), 0);
    out_ready = 1'b1;
    repeat (4) tick();
    check("flush_drop", 64'(n_out - nb), 0);

    // Illegal stream and counter saturation.
    out_ready = 1'b1;
    repeat (3) send(32'h0000007F, 8'h80);
    repeat (4) tick();
    check("ill3_c2", 64'(cnt0), 3);
    check("ill3_c16", 64'(cnt1), 3);
    repeat (2) send(32'h0000007F, 8'h81);
    repeat (4) tick();
    check("sat_c2", 64'(cnt0), 3);
    check("ill5_c16", 64'(cnt1), 5);

    // Reset mid-stream discards in-flight entries.
    out_ready = 1'b0;
    send(32'h00F23403, 8'h90);
    send(32'h0000007F, 8'h91);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_vld", 64'(bus0.out_valid), 0);
    check("rst_mid_cnt", 64'(cnt1), 0);
    nb = n_out;
    out_ready = 1'b1;
    repeat (4) tick();
    check("rst_mid_drop", 64'(n_out - nb), 0);

    // Randomized traffic with stalls, flushes and occasional resets.
    repeat (800) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_tag    = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    check("drain_empty", 64'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
